ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard over the shared PS2_CLK/PS2_DATA open-collector lines, for example 0xED plus an LED mask to set the keyboard LEDs. It runs the full host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, and device acknowledge. It sits beside the keyboard decoder; top-level tri-state buffers turn its `*_oe` outputs into a low drive and otherwise release the lines. `busy` is exported so the decoder can ignore line activity during a host transmission.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 183 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host-side blocks.
//   - ps2_tx_state_t : state encoding of the host-to-device transmitter
//   - CMD_SET_LEDS / RSP_ACK / CMD_RESET : common keyboard command bytes
//   - odd_parity()   : parity bit that makes the 9-bit data+parity word odd
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_RELEASE
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for the raw PS2_CLK / PS2_DATA lines plus
// a registered falling-edge detect on the synchronized clock.
// Ports:
//   clk, rst          system clock, async active-high reset
//   ps2_clk_i         raw PS2_CLK level
//   ps2_data_i        raw PS2_DATA level
//   clk_s, data_s     synchronized line levels
//   fe                one-cycle pulse, 3 clk cycles after a PS2_CLK fall
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s,
    output logic data_s,
    output logic fe
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_d;

    // Lines idle high, so reset the chains to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
            clk_d   <= 1'b1;
            fe      <= 1'b0;
        end else begin
            clk_ff  <= {clk_ff[0], ps2_clk_i};
            data_ff <= {data_ff[0], ps2_data_i};
            clk_d   <= clk_ff[1];
            fe      <= clk_d & ~clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one byte using the
// request-to-send sequence (clock inhibit, start, 8 data LSB-first, odd
// parity, stop) and samples the device acknowledge.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   tx_data, tx_valid        byte and send request
//   tx_ready                 high only in IDLE; accept on tx_valid && tx_ready
//   busy                     high whenever not in IDLE
//   done, ack_ok             one-cycle completion pulse and acknowledge flag
//   err                      one-cycle inactivity timeout pulse
//   ps2_clk_i, ps2_data_i    raw line levels
//   ps2_clk_oe, ps2_data_oe  1 = pull the line low
// Compile option: define PS2_HOST_TX_TIMEOUT_EN to enable the inactivity
// timeout; without it the block waits on the device forever and err is 0.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 10000,
    parameter int TIMEOUT_CYC = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);

    ps2_tx_state_t state;
    logic [7:0]    data_q;
    logic          par_q;
    logic [IW-1:0] inh_cnt;
    logic [3:0]    bit_n;
    logic          ack_ok_q;

    logic clk_s, data_s, fe;

    ps2_line_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .fe         (fe)
    );

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    logic          to_active;
    logic          to_hit;

    assign to_active = (state == ST_REQ) || (state == ST_SHIFT) ||
                       (state == ST_ACK) || (state == ST_RELEASE);
    // An edge this cycle restarts the window, so it can never time out.
    assign to_hit    = to_active && !fe && (to_cnt == TW'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            err         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            data_q      <= '0;
            par_q       <= 1'b0;
            inh_cnt     <= '0;
            bit_n       <= '0;
            ack_ok_q    <= 1'b0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            done   <= 1'b0;
            ack_ok <= 1'b0;
            err    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // tx_ready comes back one cycle after done/err.
                    tx_ready    <= 1'b1;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        data_q     <= tx_data;
                        par_q      <= odd_parity(tx_data);
                        inh_cnt    <= '0;
                        bit_n      <= '0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == IW'(INHIBIT_CYC - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b1;    // start bit
                        state       <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (fe) begin
                        bit_n       <= 4'd1;
                        ps2_data_oe <= ~data_q[0];
                        state       <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // bit_n holds the count before this edge; the bit put on
                    // the line is number bit_n+1 of the frame.
                    if (fe) begin
                        bit_n <= bit_n + 4'd1;
                        if (bit_n <= 4'd7) begin
                            ps2_data_oe <= ~data_q[bit_n[2:0]];
                        end else if (bit_n == 4'd8) begin
                            ps2_data_oe <= ~par_q;
                        end else begin
                            ps2_data_oe <= 1'b0;    // stop bit
                            state       <= ST_ACK;
                        end
                    end
                end

                ST_ACK: begin
                    if (fe) begin
                        ack_ok_q <= ~data_s;
                        state    <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (clk_s && data_s) begin
                        done   <= 1'b1;
                        ack_ok <= ack_ok_q;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
            // Held at zero through INHIBIT so the window starts on REQ entry.
            if (fe || state == ST_INHIBIT)
                to_cnt <= '0;
            else if (to_active)
                to_cnt <= to_cnt + 1'b1;

            // Overrides any same-cycle completion so done and err never overlap.
            if (to_hit) begin
                err         <= 1'b1;
                done        <= 1'b0;
                ack_ok      <= 1'b0;
                busy        <= 1'b0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                state       <= ST_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a behavioural PS/2
// device on wired-AND lines. The device clock is scaled up from 12.5 kHz to
// keep runs short. Timeout checks compile only with PS2_HOST_TX_TIMEOUT_EN.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int IC   = 40;
    localparam int TC   = 400;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, ack_ok, err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_ln, data_ln;

    assign clk_ln  = ~(ps2_clk_oe | dev_clk_low);
    assign data_ln = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYC(IC), .TIMEOUT_CYC(TC)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .err         (err),
        .ps2_clk_i   (clk_ln),
        .ps2_data_i  (data_ln),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled away from the active edge.
    int   n_done = 0, n_err = 0, n_start = 0, n_both = 0;
    int   coe_run = 0, last_coe_len = 0;
    logic prev_coe = 1'b0, prev_done = 1'b0;
    logic last_ack = 1'b0, rdy_at_done = 1'b0, rdy_after_done = 1'b0;

    always @(negedge clk) begin
        prev_coe  <= ps2_clk_oe;
        prev_done <= done;
        if (ps2_clk_oe) coe_run <= coe_run + 1;
        else begin
            if (prev_coe) last_coe_len <= coe_run;
            coe_run <= 0;
        end
        if (ps2_clk_oe && !prev_coe) n_start <= n_start + 1;
        if (done) begin
            n_done      <= n_done + 1;
            last_ack    <= ack_ok;
            rdy_at_done <= tx_ready;
        end
        if (prev_done) rdy_after_done <= tx_ready;
        if (err) n_err <= n_err + 1;
        if (done && err) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: frame as a device sees it, index 0 = start bit.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        f = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        chk("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk("busy_T1", busy, 1);
        chk("clk_oe_T1", ps2_clk_oe, 1);
    endtask

    // Device: samples data on each clock-line rise (the inhibit release
    // gives the start bit), then clocks 11 pulses; the 11th is the ack.
    // rst_at>0 stops with the clock held low after that pulse's fall.
    task automatic device(input bit ack, input int rst_at, input bit inject,
                          output logic [10:0] bits, output logic par_oe);
        int t;
        bits   = '0;
        par_oe = 1'b0;
        t = 0;
        while (clk_ln !== 1'b1 && t < IC + 20) begin
            @(negedge clk);
            t++;
        end
        if (clk_ln !== 1'b1) chk("inhibit_release", 0, 1);
        repeat (3) @(negedge clk);
        bits[0] = data_ln;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) dev_data_low = ack;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == rst_at) begin
                repeat (6) @(negedge clk);
                return;
            end
            for (int k = 0; k < HALF; k++) begin
                @(negedge clk);
                if (inject && i == 3) begin
                    if (k == 0) begin
                        tx_valid = 1'b1;
                        tx_data  = 8'h55;
                    end else if (k == 1) begin
                        tx_valid = 1'b0;
                    end
                end
            end
            dev_clk_low = 1'b0;
            if (i <= 10) begin
                @(negedge clk);
                bits[i] = data_ln;
                if (i == 9) par_oe = ps2_data_oe;
            end else begin
                repeat (3) @(negedge clk);
                dev_data_low = 1'b0;
            end
        end
    endtask

    logic last_par_oe;

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit inject);
        logic [10:0] bits;
        logic        pov;
        int          nd, ns, t;
        nd = n_done;
        ns = n_start;
        send(b);
        device(ack, 0, inject, bits, pov);
        t = 0;
        while (n_done == nd && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("done_count", n_done - nd, 1);
        chk("frame_bits", {21'd0, bits}, {21'd0, frame_of(b)});
        chk("ack_ok", last_ack, ack);
        chk("ready_at_done", rdy_at_done, 0);
        repeat (2) @(negedge clk);
        chk("ready_after_done", rdy_after_done, 1);
        chk("busy_after_done", busy, 0);
        chk("inhibit_len", last_coe_len, IC);
        repeat (40) @(negedge clk);
        chk("frames_started", n_start - ns, 1);
        last_par_oe = pov;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits;
        logic        pov;
        int          nd, t, diff;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_ok", ack_ok, 0);
        chk("rst_err", err, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // LED command, acknowledged
        run_frame(CMD_SET_LEDS, 1'b1, 1'b0);
        // parity bit 0 -> host pulls data low during the parity bit
        run_frame(8'h07, 1'b1, 1'b0);
        chk("par_oe_07", last_par_oe, 1);
        // device does not acknowledge
        run_frame(RSP_ACK, 1'b0, 1'b0);

        // reset after the 5th falling edge; 0xA3 bit4=0 so data_oe is high
        nd = n_done;
        send(8'hA3);
        device(1'b1, 5, 1'b0, bits, pov);
        chk("pre_rst_data_oe", ps2_data_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_data_oe", ps2_data_oe, 0);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", n_done - nd, 0);
        run_frame(8'h00, 1'b1, 1'b0);

        // request while busy is dropped
        run_frame(8'hC6, 1'b1, 1'b1);

        // randomized frames
        for (int r = 0; r < 10; r++) begin
            logic [7:0] b;
            bit         a;
            b = (r == 0) ? CMD_RESET : 8'($urandom);
            a = 1'($urandom_range(0, 1));
            run_frame(b, a, 1'b0);
        end

`ifdef PS2_HOST_TX_TIMEOUT_EN
        // silent device -> inactivity timeout
        send(8'h3C);
        t = 0;
        while (!err && t < IC + TC + 50) begin
            @(negedge clk);
            t++;
        end
        diff = cyc - acc_cyc;
        chk("to_err_seen", err, 1);
        chk("to_window", (diff >= IC + TC - 2 && diff <= IC + TC + 2), 1);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);
        chk("to_no_done", done, 0);
        @(negedge clk);
        chk("to_tx_ready", tx_ready, 1);
        chk("to_err_one_cycle", err, 0);
`else
        chk("err_never", n_err, 0);
`endif
        chk("done_err_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
